// File: rtl/force_ctrl_pkg.sv
// force_ctrl_pkg
//   Shared types for the force/override controller.
//   mode_e     : command mode carried on i_cmd_mode.
//   ch_state_e : per-channel override state.
package force_ctrl_pkg;

    typedef enum logic [1:0] {
        RELEASE = 2'd0,
        FORCE0  = 2'd1,
        FORCE1  = 2'd2,
        FORCEZ  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TIMED = 2'd1,
        HELD  = 2'd2
    } ch_state_e;

endpackage

// File: rtl/force_ctrl_if.sv
// I
//   One overridable scalar per channel.
//   z : channel value; driven by the channel (modport P) as either the
//       pass-through input or the latched override (0/1/high-impedance).
interface I;
    logic z;
    modport P (output z);
endinterface

// File: rtl/force_ch.sv
// force_ch
//   One channel of the override controller: state machine, hold counter,
//   latched override value, and the driver of its interface element.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   a_i           : pass-through value when not overridden
//   cmd_hit_i     : an accepted command targets this channel this cycle
//   cmd_mode_i    : command mode (RELEASE/FORCE0/FORCE1/FORCEZ)
//   cmd_hold_i    : override duration in cycles, 0 = indefinite
//   forced_o      : channel is overridden
//   expire_o      : last cycle of a timed override (suppressed by a command)
//   z_if          : driven channel value
module force_ch
    import force_ctrl_pkg::*;
#(
    parameter int unsigned HOLD_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              a_i,
    input  logic              cmd_hit_i,
    input  logic [1:0]        cmd_mode_i,
    input  logic [HOLD_W-1:0] cmd_hold_i,
    output logic              forced_o,
    output logic              expire_o,
    I.P                       z_if
);

    ch_state_e         state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              val_q, val_d;
    logic              hiz_q, hiz_d;
    logic              last_cycle;
    logic              drv;
    logic              hiz;

    // A timed override with one cycle remaining is on its final forced cycle;
    // the next edge returns the channel to IDLE.
    assign last_cycle = (state_q == TIMED) && (cnt_q == HOLD_W'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        hiz_d   = hiz_q;
        // A command takes priority over expiry on the same edge.
        if (cmd_hit_i) begin
            if (cmd_mode_i == RELEASE) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                val_d   = (cmd_mode_i == FORCE1);
                hiz_d   = (cmd_mode_i == FORCEZ);
                cnt_d   = cmd_hold_i;
                state_d = (cmd_hold_i == '0) ? HELD : TIMED;
            end
        end else if (state_q == TIMED) begin
            cnt_d = cnt_q - HOLD_W'(1);
            if (last_cycle) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            val_q   <= 1'b0;
            hiz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            hiz_q   <= hiz_d;
        end
    end

    assign forced_o = (state_q != IDLE);
    assign expire_o = last_cycle && !cmd_hit_i;

    // Override is a mux in front of the pass-through value; since state_q
    // resets asynchronously, reset releases the channel without a clock edge.
    assign hiz    = forced_o && hiz_q;
    assign drv    = forced_o ? val_q : a_i;
    assign z_if.z = hiz ? 1'bz : drv;

endmodule

// File: rtl/force_override_ctrl.sv
// force_override_ctrl
//   Per-channel value override controller with timed and indefinite holds.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_a          : per-channel pass-through values
//   i_en         : global command enable
//   i_cmd_valid  : command present; o_cmd_ready = i_en && !i_rst
//   i_cmd_ch     : target channel
//   i_cmd_mode   : RELEASE=0, FORCE0=1, FORCE1=2, FORCEZ=3
//   i_cmd_hold   : override duration in cycles, 0 = indefinite
//   o_a          : channel values as seen on u_I[i].z
//   o_forced     : channel overridden
//   o_expire     : pulse on the final cycle of a timed override
//   o_cmd_err    : accepted command with out-of-range channel
//   u_I          : per-channel interface elements
module force_override_ctrl
    import force_ctrl_pkg::*;
#(
    parameter int unsigned N_CH   = 8,
    parameter int unsigned HOLD_W = 8,
    parameter int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_CH-1:0]   i_a,
    input  logic              i_en,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [CH_W-1:0]   i_cmd_ch,
    input  logic [1:0]        i_cmd_mode,
    input  logic [HOLD_W-1:0] i_cmd_hold,
    output logic [N_CH-1:0]   o_a,
    output logic [N_CH-1:0]   o_forced,
    output logic [N_CH-1:0]   o_expire,
    output logic              o_cmd_err,
    I.P                       u_I [N_CH-1:0]
);

    logic cmd_acc;
    logic ch_ok;

    assign o_cmd_ready = i_en && !i_rst;
    assign cmd_acc     = i_cmd_valid && o_cmd_ready;
    // One extra bit so that N_CH itself is representable for the bound test.
    assign ch_ok       = ({1'b0, i_cmd_ch} < (CH_W + 1)'(N_CH));
    assign o_cmd_err   = cmd_acc && !ch_ok;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic hit;
        assign hit = cmd_acc && ch_ok && (i_cmd_ch == CH_W'(g));

        force_ch #(
            .HOLD_W (HOLD_W)
        ) u_ch (
            .clk_i      (i_clk),
            .rst_i      (i_rst),
            .a_i        (i_a[g]),
            .cmd_hit_i  (hit),
            .cmd_mode_i (i_cmd_mode),
            .cmd_hold_i (i_cmd_hold),
            .forced_o   (o_forced[g]),
            .expire_o   (o_expire[g]),
            .z_if       (u_I[g])
        );

        assign o_a[g] = u_I[g].z;
    end

endmodule

// File: tb/tb_force_override_ctrl.sv
// tb_force_override_ctrl
//   Directed bench for force_override_ctrl: an 8-channel instance for the
//   main behaviour and a 6-channel instance for out-of-range commands.
module tb_force_override_ctrl;
    import force_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_a;
    logic [5:0] i_a6;
    logic       i_en;
    logic       i_cmd_valid;
    logic       v6;
    logic [2:0] i_cmd_ch;
    logic [1:0] i_cmd_mode;
    logic [7:0] i_cmd_hold;

    logic       o_cmd_ready, o_cmd_err;
    logic [7:0] o_a, o_forced, o_expire;
    logic       rdy6, err6;
    logic [5:0] o_a6, forced6, expire6;

    int errors = 0;
    int checks = 0;

    I u_if8 [7:0] ();
    I u_if6 [5:0] ();

    always #5 clk = ~clk;

    force_override_ctrl #(.N_CH(8), .HOLD_W(8)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_a(i_a), .i_en(i_en),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_ch(i_cmd_ch), .i_cmd_mode(i_cmd_mode), .i_cmd_hold(i_cmd_hold),
        .o_a(o_a), .o_forced(o_forced), .o_expire(o_expire),
        .o_cmd_err(o_cmd_err), .u_I(u_if8)
    );

    force_override_ctrl #(.N_CH(6), .HOLD_W(8)) dut6 (
        .i_clk(clk), .i_rst(i_rst), .i_a(i_a6), .i_en(i_en),
        .i_cmd_valid(v6), .o_cmd_ready(rdy6),
        .i_cmd_ch(i_cmd_ch), .i_cmd_mode(i_cmd_mode), .i_cmd_hold(i_cmd_hold),
        .o_a(o_a6), .o_forced(forced6), .o_expire(expire6),
        .o_cmd_err(err6), .u_I(u_if6)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one command for a single edge; returns 1 time unit after it.
    task automatic send(input logic [2:0] ch, input logic [1:0] mode, input logic [7:0] hold);
        i_cmd_valid = 1'b1;
        i_cmd_ch    = ch;
        i_cmd_mode  = mode;
        i_cmd_hold  = hold;
        step();
        i_cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_en = 1'b1; i_a = 8'h3C; i_a6 = 6'h15;
        i_cmd_valid = 1'b1; v6 = 1'b1;
        i_cmd_ch = 3'd7; i_cmd_mode = FORCE1; i_cmd_hold = 8'd0;
        #12;
        checks++; if (o_forced !== 8'h00) begin errors++; $display("FAIL reset_forced got=%h exp=00", o_forced); end
        checks++; if (o_a !== 8'h3C) begin errors++; $display("FAIL reset_o_a got=%h exp=3c", o_a); end
        checks++; if (o_expire !== 8'h00) begin errors++; $display("FAIL reset_expire got=%h exp=00", o_expire); end
        checks++; if (o_cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", o_cmd_ready); end
        checks++; if (err6 !== 1'b0) begin errors++; $display("FAIL reset_cmd_err got=%b exp=0", err6); end
        checks++; if (o_a6 !== 6'h15) begin errors++; $display("FAIL reset_o_a6 got=%h exp=15", o_a6); end
        i_cmd_valid = 1'b0; v6 = 1'b0;
        @(negedge clk);
        i_rst = 1'b0;
        step();
        checks++; if (o_forced !== 8'h00) begin errors++; $display("FAIL post_reset_forced got=%h exp=00", o_forced); end
    endtask

    task automatic test_forcez();
        i_a = 8'hFF;
        i_cmd_valid = 1'b1; i_cmd_ch = 3'd3; i_cmd_mode = FORCEZ; i_cmd_hold = 8'd4;
        #1;
        checks++; if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL fz_ready got=%b exp=1", o_cmd_ready); end
        checks++; if (o_cmd_err !== 1'b0) begin errors++; $display("FAIL fz_cmd_err got=%b exp=0", o_cmd_err); end
        step();
        i_cmd_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            checks++; if (((o_a & 8'hF7) !== 8'hF7) || (o_a[3] === 1'b1)) begin errors++; $display("FAIL fz_o_a cyc=%0d got=%b exp=1111z111", k, o_a); end
            checks++; if (o_forced !== 8'h08) begin errors++; $display("FAIL fz_forced cyc=%0d got=%h exp=08", k, o_forced); end
            checks++; if (o_expire !== ((k == 4) ? 8'h08 : 8'h00)) begin errors++; $display("FAIL fz_expire cyc=%0d got=%h exp=%h", k, o_expire, (k == 4) ? 8'h08 : 8'h00); end
            step();
        end
        checks++; if (o_a !== 8'hFF) begin errors++; $display("FAIL fz_after_o_a got=%h exp=ff", o_a); end
        checks++; if (o_forced !== 8'h00) begin errors++; $display("FAIL fz_after_forced got=%h exp=00", o_forced); end
        checks++; if (o_expire !== 8'h00) begin errors++; $display("FAIL fz_after_expire got=%h exp=00", o_expire); end
    endtask

    task automatic test_held();
        i_a = 8'hFF;
        send(3'd0, FORCE0, 8'd0);
        for (int k = 0; k < 100; k++) begin
            i_a = k[0] ? 8'hFF : 8'hFE;
            #1;
            checks++; if ((o_a[0] !== 1'b0) || (o_forced !== 8'h01) || (o_expire !== 8'h00)) begin
                errors++; $display("FAIL held cyc=%0d o_a=%h forced=%h expire=%h exp o_a[0]=0 forced=01 expire=00", k, o_a, o_forced, o_expire);
            end
            step();
        end
        i_a = 8'hFF;
        send(3'd0, RELEASE, 8'd0);
        checks++; if (o_forced !== 8'h00) begin errors++; $display("FAIL held_rel_forced got=%h exp=00", o_forced); end
        checks++; if (o_a !== 8'hFF) begin errors++; $display("FAIL held_rel_o_a got=%h exp=ff", o_a); end
        i_a = 8'h5A;
        #1;
        checks++; if (o_a !== 8'h5A) begin errors++; $display("FAIL held_follow got=%h exp=5a", o_a); end
        // RELEASE to an idle channel: no error, no effect
        i_cmd_valid = 1'b1; i_cmd_ch = 3'd1; i_cmd_mode = RELEASE; i_cmd_hold = 8'd0;
        #1;
        checks++; if (o_cmd_err !== 1'b0) begin errors++; $display("FAIL idle_rel_err got=%b exp=0", o_cmd_err); end
        step();
        i_cmd_valid = 1'b0;
        checks++; if ((o_forced !== 8'h00) || (o_expire !== 8'h00)) begin errors++; $display("FAIL idle_rel got forced=%h expire=%h exp 00/00", o_forced, o_expire); end
    endtask

    task automatic test_collision();
        i_a = 8'h00;
        send(3'd2, FORCE0, 8'd3);
        send(3'd5, FORCE1, 8'd2);
        checks++; if ((o_forced !== 8'h24) || (o_a !== 8'h20) || (o_expire !== 8'h00)) begin
            errors++; $display("FAIL col_m2 forced=%h o_a=%h expire=%h exp 24/20/00", o_forced, o_a, o_expire);
        end
        step();
        // ch5 and ch2 both on their final cycle; a new command hits ch5
        i_cmd_valid = 1'b1; i_cmd_ch = 3'd5; i_cmd_mode = FORCE0; i_cmd_hold = 8'd2;
        #1;
        checks++; if (o_expire !== 8'h04) begin errors++; $display("FAIL col_expire got=%h exp=04", o_expire); end
        checks++; if ((o_forced !== 8'h24) || (o_a !== 8'h20)) begin errors++; $display("FAIL col_m3 forced=%h o_a=%h exp 24/20", o_forced, o_a); end
        step();
        i_cmd_valid = 1'b0;
        i_a = 8'hFF;
        #1;
        checks++; if ((o_forced !== 8'h20) || (o_a !== 8'hDF) || (o_expire !== 8'h00)) begin
            errors++; $display("FAIL col_m4 forced=%h o_a=%h expire=%h exp 20/df/00", o_forced, o_a, o_expire);
        end
        step();
        checks++; if ((o_a !== 8'hDF) || (o_expire !== 8'h20)) begin errors++; $display("FAIL col_m5 o_a=%h expire=%h exp df/20", o_a, o_expire); end
        step();
        checks++; if ((o_a !== 8'hFF) || (o_forced !== 8'h00) || (o_expire !== 8'h00)) begin
            errors++; $display("FAIL col_m6 o_a=%h forced=%h expire=%h exp ff/00/00", o_a, o_forced, o_expire);
        end
    endtask

    task automatic test_cmd_err();
        i_a6 = 6'h00;
        v6 = 1'b1; i_cmd_ch = 3'd1; i_cmd_mode = FORCE1; i_cmd_hold = 8'd0;
        step();
        checks++; if ((forced6 !== 6'h02) || (o_a6 !== 6'h02)) begin errors++; $display("FAIL err_setup forced=%h o_a=%h exp 02/02", forced6, o_a6); end
        for (int c = 7; c >= 6; c--) begin
            i_cmd_ch = 3'(c); i_cmd_mode = FORCE0; i_cmd_hold = 8'd0;
            #1;
            checks++; if (err6 !== 1'b1) begin errors++; $display("FAIL err_pulse ch=%0d got=%b exp=1", c, err6); end
            step();
            i_cmd_ch = 3'd1; i_cmd_mode = FORCE1;
            #1;
            checks++; if (forced6 !== 6'h02) begin errors++; $display("FAIL err_forced ch=%0d got=%h exp=02", c, forced6); end
        end
        v6 = 1'b0;
        #1;
        checks++; if (err6 !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", err6); end
    endtask

    task automatic test_en_reset();
        i_a = 8'h00;
        i_en = 1'b0;
        i_cmd_valid = 1'b1; i_cmd_ch = 3'd4; i_cmd_mode = FORCE1; i_cmd_hold = 8'd0;
        #1;
        checks++; if (o_cmd_ready !== 1'b0) begin errors++; $display("FAIL en_ready got=%b exp=0", o_cmd_ready); end
        step();
        i_cmd_valid = 1'b0;
        checks++; if (o_forced !== 8'h00) begin errors++; $display("FAIL en_ignored got=%h exp=00", o_forced); end
        i_en = 1'b1;
        send(3'd6, FORCE1, 8'd2);
        i_en = 1'b0;
        checks++; if ((o_forced !== 8'h40) || (o_a !== 8'h40)) begin errors++; $display("FAIL en_low_hold forced=%h o_a=%h exp 40/40", o_forced, o_a); end
        step();
        checks++; if (o_expire !== 8'h40) begin errors++; $display("FAIL en_low_expire got=%h exp=40", o_expire); end
        step();
        checks++; if ((o_forced !== 8'h00) || (o_a !== 8'h00)) begin errors++; $display("FAIL en_low_done forced=%h o_a=%h exp 00/00", o_forced, o_a); end
        i_en = 1'b1;
        for (int c = 0; c < 8; c++) send(3'(c), FORCE1, 8'd50);
        checks++; if ((o_forced !== 8'hFF) || (o_a !== 8'hFF)) begin errors++; $display("FAIL all_timed forced=%h o_a=%h exp ff/ff", o_forced, o_a); end
        i_a = 8'h3C;
        #2;
        i_rst = 1'b1;
        #1;
        checks++; if (o_forced !== 8'h00) begin errors++; $display("FAIL async_rst_forced got=%h exp=00", o_forced); end
        checks++; if (o_a !== 8'h3C) begin errors++; $display("FAIL async_rst_o_a got=%h exp=3c", o_a); end
        checks++; if ((o_cmd_ready !== 1'b0) || (o_expire !== 8'h00)) begin errors++; $display("FAIL async_rst_misc ready=%b expire=%h exp 0/00", o_cmd_ready, o_expire); end
        step();
        @(negedge clk);
        i_rst = 1'b0;
        step();
        checks++; if (o_forced !== 8'h00) begin errors++; $display("FAIL rst_release_forced got=%h exp=00", o_forced); end
    endtask

    initial begin
        test_reset();
        test_forcez();
        test_held();
        test_collision();
        test_cmd_err();
        test_en_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/force_override_ctrl.md
FORCE_OVERRIDE_CTRL -- requirements
Module: force_override_ctrl

Interface
REQ-001 Parameter N_CH, default 8: number of channels, which is the size of the SVI array; legal range 1..64.
REQ-002 Parameter HOLD_W, default 8: width of the per-channel hold counter.
REQ-003 Parameter CH_W, default $clog2(N_CH) (minimum 1): width of the channel index.
REQ-004 i_clk  input  1  the single clock; all state advances on its rising edge.
REQ-005 i_rst  input  1  reset, asynchronous and active-high.
REQ-006 u_I  interface array [N_CH-1:0] of I, modport P (z is output): one overridable scalar z per channel.
REQ-007 i_a  input  N_CH  per-channel pass-through value driven onto u_I[i].z by continuous assign.
REQ-008 i_en  input  1  global enable; when low, no new commands are accepted.
REQ-009 i_cmd_valid  input  1  command present.
REQ-010 o_cmd_ready  output  1  command accepted this cycle when i_cmd_valid is also high.
REQ-011 i_cmd_ch  input  CH_W  target channel.
REQ-012 i_cmd_mode  input  2  RELEASE=0, FORCE0=1, FORCE1=2, FORCEZ=3.
REQ-013 i_cmd_hold  input  HOLD_W  override duration in cycles; 0 means indefinite.
REQ-014 o_a  output  N_CH  o_a[i] = u_I[i].z, combinational.
REQ-015 o_forced  output  N_CH  channel i is currently overridden.
REQ-016 o_expire  output  N_CH  one-cycle pulse when channel i's timed override ends.
REQ-017 o_cmd_err  output  1  one-cycle pulse when an accepted command has i_cmd_ch >= N_CH.

Function
REQ-018 o_cmd_ready shall equal i_en && !i_rst; a command is accepted on a rising edge where i_cmd_valid && o_cmd_ready.
REQ-019 Each channel shall have a state machine with states IDLE, TIMED and HELD.
REQ-020 Accepted FORCEx, hold != 0: enter TIMED, load counter with hold, latch value (0/1/z).
REQ-021 Accepted FORCEx, hold == 0: enter HELD, latch value.
REQ-022 Accepted RELEASE: enter IDLE from any state; RELEASE to an IDLE channel is a no-op with no error.
REQ-023 In TIMED, the counter decrements each cycle; on the cycle it reaches 0, the channel returns to IDLE and o_expire[i] pulses for that cycle.
REQ-024 An override shall therefore last exactly hold cycles: o_a reflects the forced value from cycle N+1 through N+hold, where acceptance occurs at edge N, and returns to i_a[i] at cycle N+hold+1.
REQ-025 While TIMED or HELD, u_I[i].z shall be forced to the latched value and o_forced[i] shall be 1.
REQ-026 On entry to IDLE, u_I[i].z shall be released; o_a[i] then follows i_a[i] combinationally.
REQ-027 A new FORCEx command to a TIMED or HELD channel shall replace the value and counter; the forced value takes effect in the next cycle.
REQ-028 Simultaneous expiry and command on the same channel: the command wins and o_expire[i] shall not pulse; expiry on other channels proceeds normally.
REQ-029 A command with i_cmd_ch >= N_CH shall be accepted but ignored, and o_cmd_err shall pulse.
REQ-030 At most one command per cycle; channels otherwise operate independently and concurrently.
REQ-031 i_en low shall not freeze counters or release active overrides.

Reset
REQ-032 While i_rst is high: all channels IDLE, counters 0, latched values 0, all forces released, o_forced=0, o_expire=0, o_cmd_err=0, o_cmd_ready=0, o_a=i_a.
REQ-033 Reset asserted mid-override shall release the channel immediately (asynchronously), not at the next edge.

Structure
REQ-034 Package force_ctrl_pkg shall hold the mode enum (RELEASE/FORCE0/FORCE1/FORCEZ) and the channel state enum (IDLE/TIMED/HELD).
REQ-035 Sub-module force_ch shall implement one channel's state machine, counter, latched value and force/release of its u_I element; it shall be instantiated via a generate loop over N_CH.

Verification
REQ-036 FORCEZ on ch 3 with hold=4, i_a=8'hFF -> o_a=8'hF7 with bit 3 = z for 4 cycles; o_expire[3] pulses on the last cycle; then o_a=8'hFF.
REQ-037 FORCE0 on ch 0 with hold=0, wait 100 cycles, then RELEASE -> o_a[0]=0 throughout while o_forced[0]=1; o_a[0] follows i_a after release; no o_expire.
REQ-038 FORCE1 on ch 5 with hold=2, then FORCE0 on ch 5 on the expiry cycle -> no o_expire; ch 5 enters HELD/TIMED per the new hold value with value 0.
REQ-039 N_CH=6, command with ch=7 -> o_cmd_err pulses once; no change to o_forced.
REQ-040 i_rst asserted during a TIMED override on all 8 channels -> o_forced=0 and o_a=i_a with no clock edge; i_en=0 -> o_cmd_ready=0 and commands are ignored.
